// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM states, default operand width and small op decoders.
package mdu_pkg;

    localparam int MDU_W = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } mdu_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_cond_neg.sv
// Width-generic conditional two's-complement negate. Used both to take operand
// magnitudes and to reapply result signs after the unsigned core finishes.
module mdu_cond_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use shift-add over a 2W-bit accumulator; DIV/DIVU use restoring
// shift-subtract with a W-bit remainder. Operands are reduced to magnitudes on
// issue and signs are reapplied in FIXUP.
// Optional build macro MDU_EARLY_OUT_EN: multiplies leave CALC as soon as the
// remaining multiplier bits are zero (multiplier 0 skips CALC entirely).
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int W = MDU_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] src_a,
    input  logic [W-1:0] src_b,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [W-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

    mdu_state_e     state;
    logic [1:0]     op_r;
    logic           sign_a;
    logic           sign_b;
    logic           div0;
    logic [CNT_W-1:0] cnt;
    // Multiply: acc is the product so far, mcand the left-shifting multiplicand.
    // Divide: acc = {remainder, dividend/quotient}; mplier holds the divisor.
    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;

    logic           neg_a;
    logic           neg_b;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic           is_div;

    logic [W:0]     rem_sh;
    logic           div_ge;
    logic [W-1:0]   rem_nx;
    logic [2*W-1:0] acc_step;

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   res_hi;
    logic [W-1:0]   res_lo;

    logic           early_out;
    logic           skip_calc;

    assign is_div = op_is_div(op_r);
    assign neg_a  = op_is_signed(op) & src_a[W-1];
    assign neg_b  = op_is_signed(op) & src_b[W-1];

    mdu_cond_neg #(.W(W)) u_mag_a (.a(src_a), .neg(neg_a), .y(mag_a));
    mdu_cond_neg #(.W(W)) u_mag_b (.a(src_b), .neg(neg_b), .y(mag_b));

    mdu_cond_neg #(.W(2*W)) u_fix_prod (.a(acc), .neg(sign_a ^ sign_b), .y(prod_fix));
    mdu_cond_neg #(.W(W)) u_fix_quo (.a(acc[W-1:0]), .neg(sign_a ^ sign_b), .y(quo_fix));
    mdu_cond_neg #(.W(W)) u_fix_rem (.a(acc[2*W-1:W]), .neg(sign_a), .y(rem_fix));

`ifdef MDU_EARLY_OUT_EN
    // Remaining multiplier bits above the one consumed this cycle are all zero.
    assign early_out = ~is_div && (mplier[W-1:1] == '0);
    assign skip_calc = ~op_is_div(op) && (mag_b == '0);
`else
    assign early_out = 1'b0;
    assign skip_calc = 1'b0;
`endif

    // One CALC iteration: shift-add for multiply, restoring step for divide.
    always_comb begin
        rem_sh = {acc[2*W-1:W], acc[W-1]};
        div_ge = (rem_sh >= {1'b0, mplier});
        rem_nx = div_ge ? (rem_sh[W-1:0] - mplier) : rem_sh[W-1:0];
        if (is_div) begin
            acc_step = {rem_nx, acc[W-2:0], div_ge};
        end else begin
            acc_step = acc + (mplier[0] ? mcand : '0);
        end
    end

    // Signed results; divide by zero forces an all-ones quotient while the
    // remainder path already reproduces the dividend as issued.
    always_comb begin
        if (is_div) begin
            res_hi = rem_fix;
            res_lo = div0 ? '1 : quo_fix;
        end else begin
            res_hi = prod_fix[2*W-1:W];
            res_lo = prod_fix[W-1:0];
        end
    end

    // Control FSM with HI/LO ownership and registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            op_r   <= MDU_MULT;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            div0   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        op_r   <= op;
                        sign_a <= neg_a;
                        sign_b <= neg_b;
                        div0   <= (src_b == '0);
                        cnt    <= '0;
                        busy   <= 1'b1;
                        mplier <= mag_b;
                        if (op_is_div(op)) begin
                            acc   <= {{W{1'b0}}, mag_a};
                            mcand <= '0;
                        end else begin
                            acc   <= '0;
                            mcand <= {{W{1'b0}}, mag_a};
                        end
                        state <= skip_calc ? FIXUP : CALC;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + CNT_W'(1);
                    if (!is_div) begin
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                    if (cnt == LAST_ITER || early_out) state <= FIXUP;
                end
                FIXUP: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
